// File: rtl/fx_channel_scheduler_if.sv
// Engine-side handshake bundle: the scheduler drives start/enable/bits/sample,
// the bitcrusher engine returns its result and a done strobe.
interface fx_channel_scheduler_if #(
   parameter int W = 12
);
   logic         fx_start;
   logic         fx_enable;
   logic [2:0]   fx_bits;
   logic [W-1:0] fx_sample_in;
   logic [W-1:0] fx_sample_out;
   logic         fx_done;

   modport master (
      output fx_start,
      output fx_enable,
      output fx_bits,
      output fx_sample_in,
      input  fx_sample_out,
      input  fx_done
   );

   modport slave (
      input  fx_start,
      input  fx_enable,
      input  fx_bits,
      input  fx_sample_in,
      output fx_sample_out,
      output fx_done
   );
endinterface

// File: rtl/fx_channel_scheduler.sv
// Time-shares one bitcrusher engine across NCH voice channels: snapshot on tick,
// issue channels serially, publish all results together with a valid strobe.
module fx_channel_scheduler #(
   parameter int NCH     = 4,
   parameter int W       = 12,
   parameter int TIMEOUT = 48
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  sample_ready_i,
   input  logic [NCH*W-1:0]      ch_samples_i,
   input  logic [NCH-1:0]        ch_enable_i,
   input  logic [NCH*3-1:0]      ch_crush_i,
   input  logic                  err_clear_i,
   fx_channel_scheduler_if.master fx,
   output logic [NCH*W-1:0]      out_samples_o,
   output logic                  out_valid_o,
   output logic                  busy_o,
   output logic                  overrun_o,
   output logic                  timeout_err_o
);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_PUBLISH
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic [NCH-1:0][W-1:0]   snap_sample_q, snap_sample_d;
   logic [NCH-1:0]          snap_en_q, snap_en_d;
   logic [NCH-1:0][2:0]     snap_crush_q, snap_crush_d;
   logic [NCH-1:0][W-1:0]   res_q, res_d;
   logic [NCH-1:0][W-1:0]   out_samples_q, out_samples_d;
   logic                    out_valid_q, out_valid_d;
   logic                    overrun_q, overrun_d;
   logic                    timeout_err_q, timeout_err_d;

   logic                    fx_start;
   logic                    advance;
   logic                    res_wr;
   logic [W-1:0]            res_val;
   logic                    timeout_hit;
   logic                    engine_active;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      timer_d       = timer_q;
      snap_sample_d = snap_sample_q;
      snap_en_d     = snap_en_q;
      snap_crush_d  = snap_crush_q;
      res_d         = res_q;
      out_samples_d = out_samples_q;
      out_valid_d   = 1'b0;
      fx_start      = 1'b0;
      advance       = 1'b0;
      res_wr        = 1'b0;
      res_val       = '0;
      timeout_hit   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sample_ready_i) begin
               snap_sample_d = ch_samples_i;
               snap_en_d     = ch_enable_i;
               snap_crush_d  = ch_crush_i;
               idx_d         = '0;
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (snap_en_q[idx_q]) begin
               fx_start = 1'b1;
               timer_d  = '0;
               state_d  = S_WAIT;
            end else begin
               res_wr  = 1'b1;
               res_val = snap_sample_q[idx_q];
               advance = 1'b1;
            end
         end
         S_WAIT: begin
            if (fx.fx_done) begin
               res_wr  = 1'b1;
               res_val = fx.fx_sample_out;
               advance = 1'b1;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               // Engine stalled: pass the dry sample so the round still completes.
               res_wr      = 1'b1;
               res_val     = snap_sample_q[idx_q];
               timeout_hit = 1'b1;
               advance     = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_PUBLISH: begin
            out_samples_d = res_q;
            out_valid_d   = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (res_wr) begin
         res_d[idx_q] = res_val;
      end

      if (advance) begin
         if (idx_q == IW'(NCH - 1)) begin
            state_d = S_PUBLISH;
         end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_ISSUE;
         end
      end

      // A new set event takes priority over a simultaneous clear.
      overrun_d = overrun_q;
      if (sample_ready_i && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end else if (err_clear_i) begin
         overrun_d = 1'b0;
      end

      timeout_err_d = timeout_err_q;
      if (timeout_hit) begin
         timeout_err_d = 1'b1;
      end else if (err_clear_i) begin
         timeout_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         timer_q       <= '0;
         snap_sample_q <= '0;
         snap_en_q     <= '0;
         snap_crush_q  <= '0;
         res_q         <= '0;
         out_samples_q <= '0;
         out_valid_q   <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         timer_q       <= timer_d;
         snap_sample_q <= snap_sample_d;
         snap_en_q     <= snap_en_d;
         snap_crush_q  <= snap_crush_d;
         res_q         <= res_d;
         out_samples_q <= out_samples_d;
         out_valid_q   <= out_valid_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign engine_active   = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign fx.fx_start     = fx_start;
   assign fx.fx_enable    = engine_active;
   assign fx.fx_bits      = engine_active ? snap_crush_q[idx_q] : 3'd0;
   assign fx.fx_sample_in = engine_active ? snap_sample_q[idx_q] : '0;

   assign out_samples_o = out_samples_q;
   assign out_valid_o   = out_valid_q;
   assign busy_o        = (state_q != S_IDLE);
   assign overrun_o     = overrun_q;
   assign timeout_err_o = timeout_err_q;
endmodule

// File: tb/tb_fx_channel_scheduler.sv
// Scoreboard bench for fx_channel_scheduler: a behavioural engine with configurable
// latency, a reference model predicting results and out_valid timing, and a monitor.
module tb_fx_channel_scheduler;
   localparam int NCH     = 4;
   localparam int W       = 12;
   localparam int TIMEOUT = 48;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               sample_ready = 1'b0;
   logic [NCH*W-1:0]   ch_samples = '0;
   logic [NCH-1:0]     ch_enable = '0;
   logic [NCH*3-1:0]   ch_crush = '0;
   logic               err_clear = 1'b0;
   logic [NCH*W-1:0]   out_samples;
   logic               out_valid;
   logic               busy;
   logic               overrun;
   logic               timeout_err;

   fx_channel_scheduler_if #(.W(W)) fx_if ();

   fx_channel_scheduler #(.NCH(NCH), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .sample_ready_i (sample_ready),
      .ch_samples_i   (ch_samples),
      .ch_enable_i    (ch_enable),
      .ch_crush_i     (ch_crush),
      .err_clear_i    (err_clear),
      .fx             (fx_if.master),
      .out_samples_o  (out_samples),
      .out_valid_o    (out_valid),
      .busy_o         (busy),
      .overrun_o      (overrun),
      .timeout_err_o  (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NCH*W-1:0] data;
      int               due;
   } exp_t;
   exp_t sbq[$];

   // Engine behaviour knobs
   int lat = 3;
   int drop_ord = -1;
   int start_total = 0;
   int nvalid = 0;
   int coincide = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] crush_ref(input logic [W-1:0] s, input logic [2:0] b);
      logic [W-1:0] m;
      m = '1;
      m = m << b;
      return s & m;
   endfunction

   // Engine: result arrives `lat` cycles after the start cycle; drops the drop_ord-th start of a round.
   initial begin
      int ord;
      logic [W-1:0] s;
      logic [2:0] b;
      ord = 0;
      fx_if.fx_done = 1'b0;
      fx_if.fx_sample_out = '0;
      forever begin
         @(posedge clk);
         #1;
         fx_if.fx_done = 1'b0;
         if (!busy) ord = 0;
         if (fx_if.fx_start) begin
            start_total++;
            s = fx_if.fx_sample_in;
            b = fx_if.fx_bits;
            if (ord != drop_ord) begin
               ord++;
               repeat (lat) @(posedge clk);
               #1;
               fx_if.fx_done = 1'b1;
               fx_if.fx_sample_out = crush_ref(s, b);
            end else begin
               ord++;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each out_valid and checks data and arrival cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (fx_if.fx_start && fx_if.fx_done) coincide++;
            if (out_valid) begin
               nvalid++;
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out_valid cycle=%0d actual=1 required=0", cyc);
               end else begin
                  e = sbq.pop_front();
                  check("out_samples", 64'(out_samples), 64'(e.data));
                  check("out_valid_cycle", 64'(cyc), 64'(e.due));
               end
            end
         end
      end
   end

   // Reference model: predicts published samples and out_valid cycle, then issues the tick.
   task automatic tick(input logic [NCH*W-1:0] s, input logic [NCH-1:0] en, input logic [NCH*3-1:0] cr);
      exp_t e;
      int lat_sum;
      int ord;
      logic [W-1:0] x;
      lat_sum = 0;
      ord = 0;
      for (int c = 0; c < NCH; c++) begin
         x = s[c*W +: W];
         if (!en[c]) begin
            e.data[c*W +: W] = x;
            lat_sum += 1;
         end else begin
            if (ord == drop_ord) begin
               e.data[c*W +: W] = x;
               lat_sum += 1 + TIMEOUT;
            end else begin
               e.data[c*W +: W] = crush_ref(x, cr[c*3 +: 3]);
               lat_sum += 1 + lat;
            end
            ord++;
         end
      end
      e.due = cyc + 1 + lat_sum + 1;
      sbq.push_back(e);
      ch_samples = s;
      ch_enable = en;
      ch_crush = cr;
      sample_ready = 1'b1;
      @(posedge clk);
      #1;
      sample_ready = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || sbq.size() != 0) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL wait_idle_timeout actual=%0d required=<500", n);
         sbq.delete();
      end
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
   endtask

   initial begin
      logic [NCH*W-1:0] vec1;
      logic [NCH*3-1:0] cr4;
      int s0;
      int n0;
      vec1 = {12'h800, 12'h7FF, 12'hFF9, 12'd100};
      cr4  = {3'd4, 3'd4, 3'd4, 3'd4};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_samples", 64'(out_samples), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_flags", 64'({overrun, timeout_err}), 64'd0);
      check("rst_fx_outputs", 64'({fx_if.fx_start, fx_if.fx_enable, fx_if.fx_bits, fx_if.fx_sample_in}), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // All channels through the engine, L=3
      lat = 3;
      tick(vec1, 4'b1111, cr4);
      wait_idle();
      check("t1_known_result", 64'(out_samples), 64'({12'h800, 12'h7F0, 12'hFF0, 12'd96}));
      $display("round t1 out=%h", out_samples);

      // Mixed bypass: two engine starts only
      s0 = start_total;
      tick(vec1, 4'b0101, cr4);
      wait_idle();
      check("t2_start_pulses", 64'(start_total - s0), 64'd2);
      $display("round t2 out=%h starts=%0d", out_samples, start_total - s0);

      // Engine never answers on ch2
      drop_ord = 2;
      tick(vec1, 4'b1111, {3'd1, 3'd2, 3'd3, 3'd5});
      wait_idle();
      drop_ord = -1;
      check("t3_timeout_err_set", 64'(timeout_err), 64'd1);
      pulse_clear();
      check("t3_timeout_err_clear", 64'(timeout_err), 64'd0);
      $display("round t3 out=%h", out_samples);

      // Tick during a round (with a coincident clear): overrun set, round unaffected
      n0 = nvalid;
      tick({16'($urandom), 32'($urandom)}, 4'b1111, 12'($urandom));
      repeat (4) @(posedge clk);
      #1;
      sample_ready = 1'b1;
      err_clear = 1'b1;
      ch_samples = {16'($urandom), 32'($urandom)};
      @(posedge clk);
      #1;
      sample_ready = 1'b0;
      err_clear = 1'b0;
      check("t4_overrun_set", 64'(overrun), 64'd1);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      check("t4_single_valid", 64'(nvalid - n0), 64'd1);
      pulse_clear();
      check("t4_overrun_clear", 64'(overrun), 64'd0);

      // Reset while waiting on ch1
      n0 = nvalid;
      tick({16'($urandom), 32'($urandom)}, 4'b1111, 12'($urandom));
      repeat (5) @(posedge clk);
      #1;
      check("t5_in_wait", 64'(fx_if.fx_enable), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_out_samples", 64'(out_samples), 64'd0);
      check("t5_rst_busy_enable", 64'({busy, fx_if.fx_enable, fx_if.fx_sample_in}), 64'd0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("t5_no_valid_after_abort", 64'(nvalid - n0), 64'd0);
      tick({16'($urandom), 32'($urandom)}, 4'b1111, 12'($urandom));
      wait_idle();
      $display("round t5 out=%h", out_samples);

      // Random rounds: latency, enables, crush and occasional stalls
      for (int r = 0; r < 20; r++) begin
         lat = $urandom_range(1, 6);
         drop_ord = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
         tick({16'($urandom), 32'($urandom)}, 4'($urandom), 12'($urandom));
         wait_idle();
         $display("round rnd%0d lat=%0d drop=%0d out=%h", r, lat, drop_ord, out_samples);
      end
      drop_ord = -1;
      pulse_clear();

      // Sustained 64-cycle tick stream, L=1
      lat = 1;
      n0 = nvalid;
      coincide = 0;
      for (int r = 0; r < 200; r++) begin
         tick({16'($urandom), 32'($urandom)}, 4'($urandom), 12'($urandom));
         repeat (63) @(posedge clk);
         #1;
      end
      wait_idle();
      check("t6_valid_count", 64'(nvalid - n0), 64'd200);
      check("t6_overrun", 64'(overrun), 64'd0);
      check("t6_start_done_overlap", 64'(coincide), 64'd0);
      check("scoreboard_drained", 64'(sbq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end
endmodule
